// File: rtl/trg_link_pkg.sv
// Shared types and constants for the trigger-link bring-up sequencer.
// Holds the FSM state encoding, frame geometry and counter/timer width helpers.
package trg_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_TX  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_ALIGN     = 3'd3,
        ST_WAIT_BC0  = 3'd4,
        ST_RUN       = 3'd5
    } link_state_t;

    localparam int FRAME_LEN = 4;
    localparam int PHASE_W   = $clog2(FRAME_LEN);
    localparam int STATE_W   = 3;
    localparam int CNT_W     = 8;

    // Width of a timer that counts 0 .. limit-1, never narrower than one bit.
    function automatic int timer_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter used for the slow-control event counters.
// Clears only on the asynchronous reset and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/trg_link_sequencer.sv
// Bring-up and realignment controller for one trigger-link GTX transmitter:
// TX reset, PLL lock wait, training frames, BC0 alignment and frame-phase tracking.
module trg_link_sequencer
    import trg_link_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_WAIT    = 1024,
    parameter int ALIGN_FRAMES = 64
) (
    input  logic               clk_160,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               pll_lock,
    input  logic               tx_reset_done,
    input  logic               bc0_i,
    input  logic               resync_i,
    input  logic               force_realign,
    output logic               gtx_tx_reset,
    output logic               tx_sel_train,
    output logic               mgt_ready,
    output logic [PHASE_W-1:0] frame_phase,
    output logic [STATE_W-1:0] link_state,
    output logic [CNT_W-1:0]   realign_cnt,
    output logic [CNT_W-1:0]   lock_timeout_cnt
);

    localparam int RST_W  = timer_width(RST_CYCLES);
    localparam int LOCK_W = timer_width(LOCK_WAIT);
    localparam int FRM_W  = timer_width(ALIGN_FRAMES);

    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_WAIT - 1);
    localparam logic [FRM_W-1:0]   FRM_LAST   = FRM_W'(ALIGN_FRAMES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(FRAME_LEN - 1);

    link_state_t        r_state;
    link_state_t        w_state_next;
    logic [RST_W-1:0]   r_rst_timer;
    logic [LOCK_W-1:0]  r_lock_timer;
    logic [FRM_W-1:0]   r_frame_cnt;
    logic               r_frame_armed;
    logic [PHASE_W-1:0] r_phase;
    logic [STATE_W-1:0] r_link_state;
    logic               r_gtx_tx_reset;
    logic               r_tx_sel_train;
    logic               r_mgt_ready;

    logic w_resync;
    logic w_lock_lost;
    logic w_frame_tick;
    logic w_stay_align;
    logic w_realign_inc;
    logic w_timeout_inc;
    logic w_restart;
    logic w_rephase;

    assign w_resync    = resync_i | force_realign;
    assign w_lock_lost = !pll_lock &&
                         (r_state == ST_ALIGN || r_state == ST_WAIT_BC0 || r_state == ST_RUN);
    // Only frames that started inside ALIGN are counted, so a partial first frame is skipped.
    assign w_frame_tick = (r_state == ST_ALIGN) && r_frame_armed && (r_phase == PHASE_LAST);
    assign w_stay_align = (r_state == ST_ALIGN) && (w_state_next == ST_ALIGN) && !w_restart;

    always_comb begin
        w_state_next  = r_state;
        w_realign_inc = 1'b0;
        w_timeout_inc = 1'b0;
        w_restart     = 1'b0;
        w_rephase     = 1'b0;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else if (w_lock_lost) begin
            w_state_next = ST_RESET_TX;
        end else if (w_resync && r_state == ST_RUN) begin
            w_state_next  = ST_ALIGN;
            w_realign_inc = 1'b1;
        end else if (w_resync && (r_state == ST_ALIGN || r_state == ST_WAIT_BC0)) begin
            w_state_next = ST_ALIGN;
            w_restart    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_next = ST_RESET_TX;
                ST_RESET_TX:  if (r_rst_timer == RST_LAST) w_state_next = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (pll_lock && tx_reset_done) begin
                        w_state_next = ST_ALIGN;
                    end else if (r_lock_timer == LOCK_LAST) begin
                        w_state_next  = ST_RESET_TX;
                        w_timeout_inc = 1'b1;
                    end
                end
                ST_ALIGN:     if (w_frame_tick && r_frame_cnt == FRM_LAST) w_state_next = ST_WAIT_BC0;
                ST_WAIT_BC0: begin
                    if (bc0_i) begin
                        w_state_next = ST_RUN;
                        w_rephase    = 1'b1;
                    end
                end
                ST_RUN:       w_state_next = ST_RUN;
                default:      w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_160 or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_link_state   <= STATE_W'(ST_IDLE);
            r_gtx_tx_reset <= 1'b1;
            r_tx_sel_train <= 1'b1;
            r_mgt_ready    <= 1'b0;
            r_phase        <= '0;
            r_rst_timer    <= '0;
            r_lock_timer   <= '0;
            r_frame_cnt    <= '0;
            r_frame_armed  <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_link_state   <= w_state_next;
            r_gtx_tx_reset <= (w_state_next == ST_IDLE) || (w_state_next == ST_RESET_TX);
            r_tx_sel_train <= (w_state_next != ST_RUN);
            r_mgt_ready    <= (w_state_next == ST_RUN);

            // The BC0 cycle itself is phase 0, so the following cycle is phase 1.
            if (w_rephase) begin
                r_phase <= PHASE_W'(1);
            end else if (r_phase == PHASE_LAST) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PHASE_W'(1);
            end

            r_rst_timer  <= (r_state == ST_RESET_TX && w_state_next == ST_RESET_TX) ?
                            r_rst_timer + RST_W'(1) : '0;
            r_lock_timer <= (r_state == ST_WAIT_LOCK && w_state_next == ST_WAIT_LOCK) ?
                            r_lock_timer + LOCK_W'(1) : '0;

            if (w_stay_align) begin
                if (w_frame_tick) begin
                    r_frame_cnt <= r_frame_cnt + FRM_W'(1);
                end
                r_frame_armed <= r_frame_armed | (r_phase == '0);
            end else begin
                r_frame_cnt   <= '0;
                r_frame_armed <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_realign_cnt (
        .i_clk   (clk_160),
        .i_rst_n (reset_n),
        .i_inc   (w_realign_inc),
        .o_count (realign_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_lock_timeout_cnt (
        .i_clk   (clk_160),
        .i_rst_n (reset_n),
        .i_inc   (w_timeout_inc),
        .o_count (lock_timeout_cnt)
    );

    assign gtx_tx_reset = r_gtx_tx_reset;
    assign tx_sel_train = r_tx_sel_train;
    assign mgt_ready    = r_mgt_ready;
    assign frame_phase  = r_phase;
    assign link_state   = r_link_state;

endmodule

// File: tb/tb_trg_link_sequencer.sv
// Directed testbench for trg_link_sequencer: bring-up, realignment, lock loss,
// disable/reset and counter saturation (on a second, short-timer instance).
module tb_trg_link_sequencer;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RESET_TX  = 3'd1;
    localparam logic [2:0] S_WAIT_LOCK = 3'd2;
    localparam logic [2:0] S_ALIGN     = 3'd3;
    localparam logic [2:0] S_WAIT_BC0  = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;

    logic clk_160 = 1'b0;
    logic reset_n, enable, pll_lock, tx_reset_done, bc0_i, resync_i, force_realign;
    logic       gtx_tx_reset, tx_sel_train, mgt_ready;
    logic [1:0] frame_phase;
    logic [2:0] link_state;
    logic [7:0] realign_cnt, lock_timeout_cnt;

    logic       enable_sat;
    logic       sat_gtx_tx_reset, sat_tx_sel_train, sat_mgt_ready;
    logic [1:0] sat_frame_phase;
    logic [2:0] sat_link_state;
    logic [7:0] sat_realign_cnt, sat_lock_timeout_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_realign;

    always #5 clk_160 = ~clk_160;

    trg_link_sequencer dut (
        .clk_160          (clk_160),
        .reset_n          (reset_n),
        .enable           (enable),
        .pll_lock         (pll_lock),
        .tx_reset_done    (tx_reset_done),
        .bc0_i            (bc0_i),
        .resync_i         (resync_i),
        .force_realign    (force_realign),
        .gtx_tx_reset     (gtx_tx_reset),
        .tx_sel_train     (tx_sel_train),
        .mgt_ready        (mgt_ready),
        .frame_phase      (frame_phase),
        .link_state       (link_state),
        .realign_cnt      (realign_cnt),
        .lock_timeout_cnt (lock_timeout_cnt)
    );

    // Short timers so the timeout counter can reach saturation quickly.
    trg_link_sequencer #(.RST_CYCLES(2), .LOCK_WAIT(4), .ALIGN_FRAMES(2)) dut_sat (
        .clk_160          (clk_160),
        .reset_n          (reset_n),
        .enable           (enable_sat),
        .pll_lock         (1'b0),
        .tx_reset_done    (1'b1),
        .bc0_i            (1'b0),
        .resync_i         (1'b0),
        .force_realign    (1'b0),
        .gtx_tx_reset     (sat_gtx_tx_reset),
        .tx_sel_train     (sat_tx_sel_train),
        .mgt_ready        (sat_mgt_ready),
        .frame_phase      (sat_frame_phase),
        .link_state       (sat_link_state),
        .realign_cnt      (sat_realign_cnt),
        .lock_timeout_cnt (sat_lock_timeout_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk_160);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (link_state == s) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic count_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (link_state == s && n < budget) begin
            n++;
            tick(1);
        end
    endtask

    task automatic pulse_bc0();
        bc0_i = 1'b1;
        tick(1);
        bc0_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks++;
        if ({link_state, gtx_tx_reset, tx_sel_train, mgt_ready, frame_phase, realign_cnt, lock_timeout_cnt}
            !== {S_IDLE, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h",
                     {link_state, gtx_tx_reset, tx_sel_train, mgt_ready, frame_phase, realign_cnt, lock_timeout_cnt},
                     {S_IDLE, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_bringup();
        int n;
        pll_lock      = 1'b1;
        tx_reset_done = 1'b1;
        enable        = 1'b1;
        tick(1);
        n = 0;
        while (link_state == S_RESET_TX && gtx_tx_reset && n < 100) begin
            n++;
            tick(1);
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("[TB] FAIL bringup_reset_len: got %0d cycles expected 16", n);
        end
        checks++;
        if ({link_state, gtx_tx_reset} !== {S_WAIT_LOCK, 1'b0}) begin
            errors++;
            $display("[TB] FAIL bringup_wait_lock: got %h expected %h", {link_state, gtx_tx_reset}, {S_WAIT_LOCK, 1'b0});
        end
        count_state(S_WAIT_LOCK, 10, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("[TB] FAIL bringup_lock_len: got %0d cycles expected 1", n);
        end
        count_state(S_ALIGN, 400, n);
        checks++;
        if (n < 256 || n > 259) begin
            errors++;
            $display("[TB] FAIL bringup_align_len: got %0d cycles expected 256..259", n);
        end
        checks++;
        if ({link_state, tx_sel_train, mgt_ready} !== {S_WAIT_BC0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL bringup_wait_bc0: got %h expected %h", {link_state, tx_sel_train, mgt_ready}, {S_WAIT_BC0, 1'b1, 1'b0});
        end
        tick(2);
        pulse_bc0();
        checks++;
        if ({link_state, mgt_ready, tx_sel_train, gtx_tx_reset, frame_phase} !== {S_RUN, 1'b1, 1'b0, 1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL bringup_run: got %h expected %h",
                     {link_state, mgt_ready, tx_sel_train, gtx_tx_reset, frame_phase}, {S_RUN, 1'b1, 1'b0, 1'b0, 2'd1});
        end
        tick(1);
        checks++;
        if (frame_phase !== 2'd2) begin
            errors++;
            $display("[TB] FAIL bringup_phase_next: got %0d expected 2", frame_phase);
        end
    endtask

    task automatic test_bc0_in_run();
        bit ok;
        logic [1:0] exp_seq [3];
        exp_seq = '{2'd3, 2'd0, 2'd1};
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (frame_phase == 2'd2) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL bc0_run_sync: got phase %0d expected 2 within 4 cycles", frame_phase);
        end
        pulse_bc0();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick(1);
            checks++;
            if ({link_state, frame_phase} !== {S_RUN, exp_seq[i]}) begin
                errors++;
                $display("[TB] FAIL bc0_run_phase%0d: got %h expected %h", i, {link_state, frame_phase}, {S_RUN, exp_seq[i]});
            end
        end
    endtask

    task automatic test_resync();
        int n;
        bit ok;
        resync_i = 1'b1;
        tick(1);
        resync_i = 1'b0;
        exp_realign = 8'd1;
        checks++;
        if ({link_state, mgt_ready, tx_sel_train, realign_cnt} !== {S_ALIGN, 1'b0, 1'b1, exp_realign}) begin
            errors++;
            $display("[TB] FAIL resync_enter: got %h expected %h",
                     {link_state, mgt_ready, tx_sel_train, realign_cnt}, {S_ALIGN, 1'b0, 1'b1, exp_realign});
        end
        tick(99);
        force_realign = 1'b1;
        tick(1);
        force_realign = 1'b0;
        checks++;
        if ({link_state, realign_cnt} !== {S_ALIGN, exp_realign}) begin
            errors++;
            $display("[TB] FAIL align_restart: got %h expected %h", {link_state, realign_cnt}, {S_ALIGN, exp_realign});
        end
        count_state(S_ALIGN, 400, n);
        checks++;
        if (n < 256 || n > 259) begin
            errors++;
            $display("[TB] FAIL align_restart_len: got %0d cycles expected 256..259", n);
        end
        pulse_bc0();
        checks++;
        if ({link_state, mgt_ready, frame_phase} !== {S_RUN, 1'b1, 2'd1}) begin
            errors++;
            $display("[TB] FAIL resync_return: got %h expected %h", {link_state, mgt_ready, frame_phase}, {S_RUN, 1'b1, 2'd1});
        end
        tick(3);
        force_realign = 1'b1;
        tick(1);
        force_realign = 1'b0;
        exp_realign = 8'd2;
        checks++;
        if ({link_state, mgt_ready, realign_cnt} !== {S_ALIGN, 1'b0, exp_realign}) begin
            errors++;
            $display("[TB] FAIL force_realign_run: got %h expected %h", {link_state, mgt_ready, realign_cnt}, {S_ALIGN, 1'b0, exp_realign});
        end
        wait_state(S_WAIT_BC0, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL wait_bc0_timeout: got state %0d expected %0d", link_state, S_WAIT_BC0);
        end
        bc0_i    = 1'b1;
        resync_i = 1'b1;
        tick(1);
        bc0_i    = 1'b0;
        resync_i = 1'b0;
        checks++;
        if ({link_state, mgt_ready, realign_cnt} !== {S_ALIGN, 1'b0, exp_realign}) begin
            errors++;
            $display("[TB] FAIL bc0_with_resync: got %h expected %h", {link_state, mgt_ready, realign_cnt}, {S_ALIGN, 1'b0, exp_realign});
        end
        wait_state(S_WAIT_BC0, 300, ok);
        pulse_bc0();
        checks++;
        if ({ok, link_state, frame_phase} !== {1'b1, S_RUN, 2'd1}) begin
            errors++;
            $display("[TB] FAIL rerun_after_resync: got %h expected %h", {ok, link_state, frame_phase}, {1'b1, S_RUN, 2'd1});
        end
    endtask

    task automatic test_lock_loss_resync();
        bit ok;
        tick(2);
        pll_lock = 1'b0;
        resync_i = 1'b1;
        tick(1);
        resync_i = 1'b0;
        pll_lock = 1'b1;
        checks++;
        if ({link_state, gtx_tx_reset, mgt_ready, realign_cnt} !== {S_RESET_TX, 1'b1, 1'b0, exp_realign}) begin
            errors++;
            $display("[TB] FAIL lock_loss_resync: got %h expected %h",
                     {link_state, gtx_tx_reset, mgt_ready, realign_cnt}, {S_RESET_TX, 1'b1, 1'b0, exp_realign});
        end
        wait_state(S_WAIT_BC0, 400, ok);
        pulse_bc0();
        checks++;
        if ({ok, link_state, mgt_ready} !== {1'b1, S_RUN, 1'b1}) begin
            errors++;
            $display("[TB] FAIL relock_run: got %h expected %h", {ok, link_state, mgt_ready}, {1'b1, S_RUN, 1'b1});
        end
    endtask

    task automatic test_disable_and_reset();
        bit ok;
        enable = 1'b0;
        tick(1);
        checks++;
        if ({link_state, gtx_tx_reset, tx_sel_train, mgt_ready, realign_cnt} !== {S_IDLE, 1'b1, 1'b1, 1'b0, exp_realign}) begin
            errors++;
            $display("[TB] FAIL disable_idle: got %h expected %h",
                     {link_state, gtx_tx_reset, tx_sel_train, mgt_ready, realign_cnt}, {S_IDLE, 1'b1, 1'b1, 1'b0, exp_realign});
        end
        enable = 1'b1;
        wait_state(S_ALIGN, 100, ok);
        tick(20);
        checks++;
        if ({ok, link_state} !== {1'b1, S_ALIGN}) begin
            errors++;
            $display("[TB] FAIL reenter_align: got %h expected %h", {ok, link_state}, {1'b1, S_ALIGN});
        end
        reset_n = 1'b0;
        enable  = 1'b0;
        #2;
        checks++;
        if ({link_state, gtx_tx_reset, tx_sel_train, mgt_ready, frame_phase, realign_cnt, lock_timeout_cnt}
            !== {S_IDLE, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h",
                     {link_state, gtx_tx_reset, tx_sel_train, mgt_ready, frame_phase, realign_cnt, lock_timeout_cnt},
                     {S_IDLE, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0});
        end
        tick(1);
        reset_n = 1'b1;
        exp_realign = 8'd0;
    endtask

    task automatic test_lock_timeout();
        pll_lock      = 1'b0;
        tx_reset_done = 1'b1;
        enable        = 1'b1;
        tick(1);
        for (int k = 1; k <= 3; k++) begin
            tick(1039);
            checks++;
            if ({link_state, lock_timeout_cnt} !== {S_WAIT_LOCK, 8'(k - 1)}) begin
                errors++;
                $display("[TB] FAIL timeout_pre%0d: got %h expected %h", k, {link_state, lock_timeout_cnt}, {S_WAIT_LOCK, 8'(k - 1)});
            end
            tick(1);
            checks++;
            if ({link_state, gtx_tx_reset, lock_timeout_cnt} !== {S_RESET_TX, 1'b1, 8'(k)}) begin
                errors++;
                $display("[TB] FAIL timeout_post%0d: got %h expected %h", k,
                         {link_state, gtx_tx_reset, lock_timeout_cnt}, {S_RESET_TX, 1'b1, 8'(k)});
            end
        end
        enable   = 1'b0;
        pll_lock = 1'b1;
        tick(1);
    endtask

    task automatic test_saturation();
        enable_sat = 1'b1;
        tick(1);
        tick(6 * 254);
        checks++;
        if ({sat_link_state, sat_lock_timeout_cnt} !== {S_RESET_TX, 8'd254}) begin
            errors++;
            $display("[TB] FAIL sat_254: got %h expected %h", {sat_link_state, sat_lock_timeout_cnt}, {S_RESET_TX, 8'd254});
        end
        tick(6 * 10);
        checks++;
        if (sat_lock_timeout_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_255: got %0d expected 255", sat_lock_timeout_cnt);
        end
        enable_sat = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        pll_lock      = 1'b0;
        tx_reset_done = 1'b0;
        bc0_i         = 1'b0;
        resync_i      = 1'b0;
        force_realign = 1'b0;
        enable_sat    = 1'b0;
        exp_realign   = 8'd0;
        test_reset();
        test_bringup();
        test_bc0_in_run();
        test_resync();
        test_lock_loss_resync();
        test_disable_and_reset();
        test_lock_timeout();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
